// File: rtl/acum_pkg.sv
// Shared definitions for the saturating accumulator slice.
// FSM encoding, saturation limits and width helper.
package acum_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACUM   = 2'd1;
  localparam logic [1:0] ST_SALIDA = 2'd2;

  function automatic longint max_val(input int largo);
    return (longint'(1) << largo) - longint'(1);
  endfunction

  // Symmetric negative limit; the most negative code is never produced
  function automatic longint min_sat(input int largo);
    return -max_val(largo);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acumulador_saturado_if.sv
// Sample-in / result-out handshake bundle.
// Master side is the pipeline driving samples and taking results.
interface acumulador_saturado_if
  import acum_pkg::*;
#(
  parameter int LARGO = 20
);

  logic               inicio;
  logic signed [LARGO:0] dato_in;
  logic               valid_in;
  logic               ready_in;
  logic signed [LARGO:0] y_out;
  logic               valid_out;
  logic               ready_out;
  logic               ovf;
  logic               unf;
  logic               ocupado;

  modport master (
    output inicio, dato_in, valid_in, ready_out,
    input  ready_in, y_out, valid_out, ovf, unf, ocupado
  );

  modport slave (
    input  inicio, dato_in, valid_in, ready_out,
    output ready_in, y_out, valid_out, ovf, unf, ocupado
  );

endinterface

// File: rtl/sumador_saturado.sv
// Combinational symmetric saturating adder.
// Sum is formed one bit wider, then clamped to +/-MAX.
module sumador_saturado
  import acum_pkg::*;
#(
  parameter int LARGO = 20
) (
  input  logic signed [LARGO:0] a,
  input  logic signed [LARGO:0] b,
  output logic signed [LARGO:0] y,
  output logic                  ovf_ev,
  output logic                  unf_ev
);

  localparam logic signed [LARGO+1:0] MAXX =
    (LARGO+2)'(max_val(LARGO));
  localparam logic signed [LARGO+1:0] MINX =
    (LARGO+2)'(min_sat(LARGO));
  localparam logic signed [LARGO:0] MAX =
    (LARGO+1)'(max_val(LARGO));
  localparam logic signed [LARGO:0] MIN =
    (LARGO+1)'(min_sat(LARGO));

  logic signed [LARGO+1:0] suma;

  // Wide add, range check and clamp
  always_comb begin
    suma   = {a[LARGO], a} + {b[LARGO], b};
    ovf_ev = suma > MAXX;
    unf_ev = suma < MINX;
    y      = suma[LARGO:0];
    if (ovf_ev) y = MAX;
    if (unf_ev) y = MIN;
  end

endmodule

// File: rtl/acumulador_saturado.sv
// Burst accumulator: TERMINOS samples into one saturated sum.
// Result held with valid/ready; sticky ovf/unf per burst.
module acumulador_saturado
  import acum_pkg::*;
#(
  parameter int LARGO    = 20,
  parameter int TERMINOS = 8
) (
  input logic clk,
  input logic reset_n,
  acumulador_saturado_if.slave bus
);

  localparam int CW = clog2(TERMINOS) + 1;
  localparam logic [CW-1:0] ULT = CW'(TERMINOS - 1);

  logic [1:0]            state_q, state_d;
  logic signed [LARGO:0] acc_q, acc_d;
  logic signed [LARGO:0] y_q, y_d;
  logic signed [LARGO:0] suma;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  ovf_ev, unf_ev;

  sumador_saturado #(
    .LARGO(LARGO)
  ) u_sum (
    .a      (acc_q),
    .b      (bus.dato_in),
    .y      (suma),
    .ovf_ev (ovf_ev),
    .unf_ev (unf_ev)
  );

  // Next-state: burst control, accumulation and result capture
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (bus.inicio) begin
          state_d = ST_ACUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      state_q == ST_ACUM: begin
        if (bus.valid_in) begin
          acc_d = suma;
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | ovf_ev;
          unf_d = unf_q | unf_ev;
          if (cnt_q == ULT) begin
            y_d     = suma;
            state_d = ST_SALIDA;
          end
        end
      end
      state_q == ST_SALIDA: begin
        if (bus.ready_out) begin
          if (bus.inicio) begin
            state_d = ST_ACUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.ready_in  = state_q == ST_ACUM;
  assign bus.valid_out = state_q == ST_SALIDA;
  assign bus.ocupado   = state_q != ST_IDLE;
  assign bus.y_out     = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_acumulador_saturado.sv
// Randomized self-checking bench for acumulador_saturado.
// Integer clamp model; TERMINOS=4 and TERMINOS=1 instances.
module tb_acumulador_saturado;

  localparam int L = 20;
  localparam longint MAXV = (longint'(1) << L) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  acumulador_saturado_if #(.LARGO(L)) b4 ();
  acumulador_saturado_if #(.LARGO(L)) b1 ();

  acumulador_saturado #(.LARGO(L), .TERMINOS(4)) dut4 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (b4.slave)
  );

  acumulador_saturado #(.LARGO(L), .TERMINOS(1)) dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (b1.slave)
  );

  logic [L:0] smp [4];
  logic [L:0] exp_y;
  logic       exp_ovf;
  logic       exp_unf;

  // Reference: running integer sum clamped to +/-MAX after each sample
  task automatic model(input int n);
    longint acc;
    acc = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'($signed(smp[i]));
      if (acc > MAXV) begin
        acc = MAXV;
        exp_ovf = 1'b1;
      end else if (acc < -MAXV) begin
        acc = -MAXV;
        exp_unf = 1'b1;
      end
    end
    exp_y = acc[L:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_burst(input bit start, input bit gaps);
    if (start) begin
      b4.inicio = 1'b1;
      tick();
      b4.inicio = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          b4.valid_in = 1'b0;
          b4.dato_in  = L'($urandom);
          tick();
        end
      end
      b4.valid_in = 1'b1;
      b4.dato_in  = smp[i];
      tick();
    end
    b4.valid_in = 1'b0;
  endtask

  task automatic handshake4();
    b4.ready_out = 1'b1;
    tick();
    b4.ready_out = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({b4.y_out, b4.valid_out, b4.ready_in, b4.ovf, b4.unf, b4.ocupado} !== '0) begin
      errors++;
      $display("FAIL reset4 got y=%h v=%b r=%b o=%b u=%b b=%b exp all 0",
        b4.y_out, b4.valid_out, b4.ready_in, b4.ovf, b4.unf, b4.ocupado);
    end
    checks++;
    if ({b1.y_out, b1.valid_out, b1.ready_in, b1.ocupado} !== '0) begin
      errors++;
      $display("FAIL reset1 got y=%h v=%b r=%b b=%b exp all 0",
        b1.y_out, b1.valid_out, b1.ready_in, b1.ocupado);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    smp[0] = 21'h000010;
    smp[1] = 21'h000020;
    smp[2] = 21'h1FFFF0;
    smp[3] = 21'h000005;
    drive_burst(1'b1, 1'b0);
    checks++;
    if ({b4.valid_out, b4.y_out} !== {1'b1, 21'h000025}) begin
      errors++;
      $display("FAIL nominal_y got v=%b y=%h exp v=1 y=000025", b4.valid_out, b4.y_out);
    end
    checks++;
    if ({b4.ovf, b4.unf, b4.ready_in} !== 3'b000) begin
      errors++;
      $display("FAIL nominal_flags got o=%b u=%b r=%b exp 000", b4.ovf, b4.unf, b4.ready_in);
    end
    tick();
    tick();
    checks++;
    if ({b4.valid_out, b4.y_out} !== {1'b1, 21'h000025}) begin
      errors++;
      $display("FAIL nominal_hold got v=%b y=%h exp v=1 y=000025", b4.valid_out, b4.y_out);
    end
    handshake4();
    checks++;
    if ({b4.valid_out, b4.ocupado, b4.y_out} !== {2'b00, 21'h000025}) begin
      errors++;
      $display("FAIL nominal_idle got v=%b b=%b y=%h exp v=0 b=0 y=000025",
        b4.valid_out, b4.ocupado, b4.y_out);
    end
  endtask

  task automatic test_overflow();
    smp[0] = 21'h0FFFFF;
    smp[1] = 21'h000001;
    smp[2] = 21'h1FFFFF;
    smp[3] = 21'h000000;
    model(4);
    drive_burst(1'b1, 1'b0);
    checks++;
    if ({b4.y_out, b4.ovf, b4.unf} !== {exp_y, exp_ovf, exp_unf}) begin
      errors++;
      $display("FAIL ovf_burst got y=%h o=%b u=%b exp y=%h o=%b u=%b",
        b4.y_out, b4.ovf, b4.unf, exp_y, exp_ovf, exp_unf);
    end
    handshake4();
    checks++;
    if ({b4.ovf, b4.ocupado} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_sticky got o=%b b=%b exp o=1 b=0", b4.ovf, b4.ocupado);
    end
  endtask

  task automatic test_underflow();
    smp[0] = 21'h100000;
    smp[1] = 21'h000000;
    smp[2] = 21'h000000;
    smp[3] = 21'h000000;
    model(4);
    drive_burst(1'b1, 1'b0);
    checks++;
    if ({b4.y_out, b4.ovf, b4.unf} !== {exp_y, exp_ovf, exp_unf}) begin
      errors++;
      $display("FAIL unf_burst got y=%h o=%b u=%b exp y=%h o=%b u=%b",
        b4.y_out, b4.ovf, b4.unf, exp_y, exp_ovf, exp_unf);
    end
    handshake4();
    checks++;
    if ({b4.unf, b4.y_out} !== {1'b1, 21'h100001}) begin
      errors++;
      $display("FAIL unf_sticky got u=%b y=%h exp u=1 y=100001", b4.unf, b4.y_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) smp[i] = L'($urandom);
    model(4);
    drive_burst(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({b4.valid_out, b4.ready_in, b4.y_out, b4.ovf, b4.unf} !==
          {2'b10, exp_y, exp_ovf, exp_unf}) begin
        errors++;
        $display("FAIL b2b_stall%0d got v=%b r=%b y=%h exp v=1 r=0 y=%h",
          c, b4.valid_out, b4.ready_in, b4.y_out, exp_y);
      end
      tick();
    end
    b4.ready_out = 1'b1;
    b4.inicio    = 1'b1;
    tick();
    b4.ready_out = 1'b0;
    b4.inicio    = 1'b0;
    checks++;
    if ({b4.ready_in, b4.valid_out, b4.ovf, b4.unf, b4.ocupado} !== 5'b10001) begin
      errors++;
      $display("FAIL b2b_restart got r=%b v=%b o=%b u=%b b=%b exp 10001",
        b4.ready_in, b4.valid_out, b4.ovf, b4.unf, b4.ocupado);
    end
    for (int i = 0; i < 4; i++) smp[i] = L'($urandom);
    model(4);
    drive_burst(1'b0, 1'b1);
    checks++;
    if ({b4.valid_out, b4.y_out, b4.ovf, b4.unf} !== {1'b1, exp_y, exp_ovf, exp_unf}) begin
      errors++;
      $display("FAIL b2b_second got v=%b y=%h o=%b u=%b exp v=1 y=%h o=%b u=%b",
        b4.valid_out, b4.y_out, b4.ovf, b4.unf, exp_y, exp_ovf, exp_unf);
    end
    handshake4();
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) smp[i] = L'($urandom);
        else smp[i] = L'($urandom_range(0, 511)) - 21'd256;
      end
      model(4);
      drive_burst(1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if ({b4.valid_out, b4.y_out, b4.ovf, b4.unf} !== {1'b1, exp_y, exp_ovf, exp_unf}) begin
        errors++;
        $display("FAIL rand%0d got v=%b y=%h o=%b u=%b exp v=1 y=%h o=%b u=%b",
          n, b4.valid_out, b4.y_out, b4.ovf, b4.unf, exp_y, exp_ovf, exp_unf);
      end
      handshake4();
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset_mid();
    b4.inicio = 1'b1;
    tick();
    b4.inicio   = 1'b0;
    b4.valid_in = 1'b1;
    b4.dato_in  = 21'h0FFFFF;
    tick();
    tick();
    b4.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b4.y_out, b4.valid_out, b4.ready_in, b4.ovf, b4.unf, b4.ocupado} !== '0) begin
      errors++;
      $display("FAIL mid_reset got y=%h v=%b r=%b o=%b u=%b b=%b exp all 0",
        b4.y_out, b4.valid_out, b4.ready_in, b4.ovf, b4.unf, b4.ocupado);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) smp[i] = 21'h000001;
    drive_burst(1'b1, 1'b0);
    checks++;
    if ({b4.valid_out, b4.y_out, b4.ovf} !== {1'b1, 21'h000004, 1'b0}) begin
      errors++;
      $display("FAIL mid_fresh got v=%b y=%h o=%b exp v=1 y=000004 o=0",
        b4.valid_out, b4.y_out, b4.ovf);
    end
    handshake4();
  endtask

  task automatic test_t1_gaps();
    b1.inicio = 1'b1;
    tick();
    b1.inicio = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({b1.ready_in, b1.valid_out} !== 2'b10) begin
        errors++;
        $display("FAIL t1_gap%0d got r=%b v=%b exp r=1 v=0", c, b1.ready_in, b1.valid_out);
      end
      tick();
    end
    b1.valid_in = 1'b1;
    b1.dato_in  = 21'h0ABCDE;
    tick();
    b1.valid_in = 1'b0;
    checks++;
    if ({b1.valid_out, b1.ready_in, b1.y_out} !== {2'b10, 21'h0ABCDE}) begin
      errors++;
      $display("FAIL t1_result got v=%b r=%b y=%h exp v=1 r=0 y=0abcde",
        b1.valid_out, b1.ready_in, b1.y_out);
    end
    b1.ready_out = 1'b1;
    tick();
    b1.ready_out = 1'b0;
    checks++;
    if ({b1.valid_out, b1.ocupado} !== 2'b00) begin
      errors++;
      $display("FAIL t1_idle got v=%b b=%b exp 00", b1.valid_out, b1.ocupado);
    end
  endtask

  initial begin
    b4.inicio = 1'b0; b4.valid_in = 1'b0;
    b4.ready_out = 1'b0; b4.dato_in = '0;
    b1.inicio = 1'b0; b1.valid_in = 1'b0;
    b1.ready_out = 1'b0; b1.dato_in = '0;
    test_reset();
    test_nominal();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_t1_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
